gemm_tile_sequencer: RTL

Control FSM that sequences one GEMM tile through gemm_datapath. It accepts a tile command, then streams SYS_DIM weight rows (wfetch) and m activation vectors (if_en, store, overwrite). It waits for accumulation to complete, then drains the active accumulator banks to a consumer. It sits between the command/buffer logic and gemm_datapath, and owns every datapath control input.

---
 rtl/gemm_tile_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/gemm_tile_sequencer.sv
// Tile control FSM for gemm_datapath: weight load, activation feed, accumulate wait,
// then bank-by-bank drain of the accumulators to a consumer.
module gemm_tile_sequencer #(
  parameter int SYS_DIM  = 16,
  parameter int M_W      = 8,
  parameter int IF_SEL_W = 3,
  parameter int W_SEL_W  = 3,
  parameter int TIMEOUT  = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [M_W-1:0]      cmd_m,
  input  logic [4:0]          cmd_n,
  input  logic                cmd_accum,
  input  logic                cmd_drain,
  input  logic [IF_SEL_W-1:0] cmd_if_sel,
  input  logic [W_SEL_W-1:0]  cmd_w_sel,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic                a_valid,
  output logic                a_ready,
  output logic                wfetch,
  output logic                if_en,
  output logic                store,
  output logic                overwrite,
  output logic [IF_SEL_W-1:0] if_mux_sel,
  output logic [W_SEL_W-1:0]  w_mux_sel,
  output logic                gt4,
  output logic                gt8,
  output logic                gt12,
  output logic [3:0]          accums_rd_en,
  input  logic [3:0]          acc_empty,
  input  logic                acc_is_done,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [1:0]          out_bank,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [4:0]      N_MAX   = 5'(SYS_DIM);
  localparam logic [M_W-1:0]  W_LAST  = M_W'(SYS_DIM - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, W_LOAD, FEED, WAIT_ACC, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic [M_W-1:0]      m_r, m_last, beat_cnt;
  logic                accum_r, drain_r;
  logic [IF_SEL_W-1:0] if_sel_r;
  logic [W_SEL_W-1:0]  w_sel_r;
  logic                gt4_r, gt8_r, gt12_r;
  logic [1:0]          bank, last_bank;
  logic [5:0]          nb;
  logic [TO_W-1:0]     wait_cnt;
  logic                cmd_legal, cmd_fire, beat, cnt_wrap, pop, timeout, err_q;

  assign cmd_legal = (cmd_m != '0) && (cmd_n != 5'd0) && (cmd_n <= N_MAX);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign nb        = ({1'b0, cmd_n} + 6'd3) >> 2;
  assign m_last    = m_r - 1'b1;
  // Weight phase always ends at SYS_DIM beats; feed and per-bank drain end at m.
  assign cnt_wrap  = (state == W_LOAD) ? (beat_cnt == W_LAST) : (beat_cnt == m_last);

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign err        = err_q;
  assign gt4        = gt4_r;
  assign gt8        = gt8_r;
  assign gt12       = gt12_r;
  assign if_mux_sel = if_sel_r;
  assign w_mux_sel  = w_sel_r;

  always_comb begin
    state_nx     = state;
    w_ready      = 1'b0;
    wfetch       = 1'b0;
    a_ready      = 1'b0;
    if_en        = 1'b0;
    store        = 1'b0;
    overwrite    = 1'b0;
    accums_rd_en = 4'b0;
    pop          = 1'b0;
    beat         = 1'b0;
    timeout      = 1'b0;
    case (state)
      IDLE: if (cmd_valid && cmd_legal) state_nx = W_LOAD;
      W_LOAD: begin
        w_ready = 1'b1;
        wfetch  = w_valid;
        beat    = w_valid;
        if (beat && cnt_wrap) state_nx = FEED;
      end
      FEED: begin
        a_ready   = 1'b1;
        if_en     = a_valid;
        store     = a_valid;
        overwrite = a_valid && !accum_r;
        beat      = a_valid;
        if (beat && cnt_wrap) state_nx = WAIT_ACC;
      end
      WAIT_ACC: begin
        if (acc_is_done) state_nx = drain_r ? DRAIN : DONE;
        else if (wait_cnt == TO_LAST) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end
      end
      DRAIN: begin
        pop          = out_ready && !acc_empty[bank];
        accums_rd_en = pop ? (4'b0001 << bank) : 4'b0;
        beat         = pop;
        if (pop && cnt_wrap && bank == last_bank) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_r       <= '0;
      accum_r   <= 1'b0;
      drain_r   <= 1'b0;
      if_sel_r  <= '0;
      w_sel_r   <= '0;
      gt4_r     <= 1'b0;
      gt8_r     <= 1'b0;
      gt12_r    <= 1'b0;
      last_bank <= 2'd0;
      beat_cnt  <= '0;
      bank      <= 2'd0;
      wait_cnt  <= '0;
      out_valid <= 1'b0;
      out_bank  <= 2'd0;
      err_q     <= 1'b0;
    end else begin
      err_q     <= (cmd_fire && !cmd_legal) || timeout;
      out_valid <= pop;
      out_bank  <= bank;
      if (cmd_fire && cmd_legal) begin
        m_r       <= cmd_m;
        accum_r   <= cmd_accum;
        drain_r   <= cmd_drain;
        if_sel_r  <= cmd_if_sel;
        w_sel_r   <= cmd_w_sel;
        gt4_r     <= cmd_n > 5'd4;
        gt8_r     <= cmd_n > 5'd8;
        gt12_r    <= cmd_n > 5'd12;
        last_bank <= 2'(nb - 6'd1);
      end else if (state_nx == IDLE) begin
        if_sel_r <= '0;
        w_sel_r  <= '0;
        gt4_r    <= 1'b0;
        gt8_r    <= 1'b0;
        gt12_r   <= 1'b0;
      end
      // One counter serves every phase; it returns to 0 at each phase/bank boundary.
      if (state_nx == IDLE)  beat_cnt <= '0;
      else if (beat)         beat_cnt <= cnt_wrap ? '0 : beat_cnt + 1'b1;
      if (state != WAIT_ACC) wait_cnt <= '0;
      else                   wait_cnt <= wait_cnt + 1'b1;
      if (state != DRAIN)    bank <= 2'd0;
      else if (pop && cnt_wrap) bank <= bank + 2'd1;
    end
  end
endmodule
